// File: rtl/bmp_ram_arb.sv
// BMP download-to-SDRAM writer and display line prefetcher.
// One memory port shared by byte writes (priority) and 32-bit pixel reads.
module bmp_ram_arb #(
  parameter int LINE_W = 640,
  parameter int FIFO_D = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        line_req,
  input  logic [8:0]  line_num,
  input  logic [8:0]  line_max,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        pix_we,
  output logic [9:0]  pix_addr,
  output logic [23:0] pix_data,
  output logic        bmp_loaded,
  output logic        bmp_err,
  output logic        busy
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD      = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;

  logic [1:0]    state;
  logic [23:0]   fa [FIFO_D];
  logic [7:0]    fd [FIFO_D];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          act_q;
  logic          fall_pend;
  logic [23:0]   data_start;
  logic [15:0]   width;
  logic          pend_v;
  logic [8:0]    pend_line;
  logic          cur_v;
  logic [8:0]    cur_line;
  logic [9:0]    x;

  logic          push_req;
  logic          pop;
  logic          full;
  logic          push;
  logic          ovf;
  logic          fifo_ne;
  logic          line_ok;
  logic          start_rd;
  logic          last_x;
  logic [8:0]    line_clamp;
  logic [8:0]    row;
  logic [23:0]   rd_addr;
  logic          unused_rdata;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_req = dl_wr && (dl_addr >= 25'd13)
                  && (dl_addr >= {1'b0, data_start});
  assign pop      = (state == S_WR) && mem_ack;
  assign full     = (cnt == CW'(FIFO_D));
  // a pop in the same cycle frees the slot the push needs
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  assign fifo_ne  = (cnt != '0);

  assign line_ok  = line_req && !dl_active && bmp_loaded;
  assign start_rd = (pend_v || cur_v) && !dl_active && bmp_loaded;
  assign last_x   = (x == 10'(LINE_W - 1));

  assign line_clamp = (line_num >= line_max) ? line_max - 9'd1 : line_num;
  // image is stored bottom-up, so display line 0 is the last file row
  assign row     = line_max - 9'd1 - cur_line;
  assign rd_addr = (24'(row) * 24'(LINE_W) + 24'(x)) << 2;

  assign busy         = (state != S_IDLE) || fifo_ne;
  assign unused_rdata = ^mem_rdata[31:24];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      act_q      <= 1'b0;
      fall_pend  <= 1'b0;
      data_start <= '0;
      width      <= '0;
      pend_v     <= 1'b0;
      pend_line  <= '0;
      cur_v      <= 1'b0;
      cur_line   <= '0;
      x          <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      bmp_loaded <= 1'b0;
      bmp_err    <= 1'b0;
    end else begin
      act_q  <= dl_active;
      pix_we <= 1'b0;

      if (!dl_active && act_q) begin
        fall_pend <= 1'b1;
      end else if (fall_pend && !fifo_ne) begin
        bmp_loaded <= ~bmp_err;
        fall_pend  <= 1'b0;
      end

      if (dl_active && !act_q) begin
        bmp_loaded <= 1'b0;
        bmp_err    <= 1'b0;
        data_start <= '0;
        width      <= '0;
        fall_pend  <= 1'b0;
      end

      if (dl_wr) begin
        case (dl_addr)
          25'd10: data_start[7:0]   <= dl_data;
          25'd11: data_start[15:8]  <= dl_data;
          25'd12: data_start[23:16] <= dl_data;
          25'd18: width[7:0]        <= dl_data;
          25'd19: begin
            width[15:8] <= dl_data;
            if ({dl_data, width[7:0]} != 16'(LINE_W))
              bmp_err <= 1'b1;
          end
          default: ;
        endcase
      end

      if (ovf)
        bmp_err <= 1'b1;

      if (push) begin
        fa[wr_ptr] <= dl_addr[23:0] - data_start;
        fd[wr_ptr] <= dl_data;
        wr_ptr     <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);

      if (line_ok) begin
        pend_v    <= 1'b1;
        pend_line <= line_clamp;
      end

      unique case (state)
        S_IDLE: begin
          if (fifo_ne) begin
            state     <= S_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fa[rd_ptr];
            mem_wdata <= fd[rd_ptr];
          end else if (start_rd) begin
            state <= S_RD;
            if (pend_v) begin
              cur_line <= pend_line;
              cur_v    <= 1'b1;
              x        <= '0;
              pend_v   <= line_ok;
            end
          end
        end
        S_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_RD: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= rd_addr;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            pix_we   <= 1'b1;
            pix_addr <= x;
            pix_data <= mem_rdata[23:0];
            if (pend_v || last_x) begin
              cur_v <= 1'b0;
              state <= S_IDLE;
            end else begin
              x     <= x + 10'd1;
              state <= fifo_ne ? S_IDLE : S_RD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_ram_arb.sv
// Directed bench for bmp_ram_arb: header/download, line fetch table,
// abort, overflow and reset-under-request sequences.
module tb_bmp_ram_arb;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        line_req = 1'b0;
  logic [8:0]  line_num = '0;
  logic [8:0]  line_max = 9'd312;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        pix_we;
  logic [9:0]  pix_addr;
  logic [23:0] pix_data;
  logic        bmp_loaded;
  logic        bmp_err;
  logic        busy;

  bmp_ram_arb #(.LINE_W(640), .FIFO_D(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .line_req(line_req), .line_num(line_num), .line_max(line_max),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .bmp_loaded(bmp_loaded), .bmp_err(bmp_err), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  logic ack_en = 1'b0;
  logic late_ack = 1'b0;
  logic [23:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [23:0] rd_q[$];
  logic [9:0]  px_a_q[$];
  logic [23:0] px_d_q[$];
  logic        p_req = 1'b0;
  logic        p_we = 1'b0;
  logic [23:0] p_addr = '0;
  logic [7:0]  p_wd = '0;

  // memory responder, pixel logger and request-stability monitor
  always @(posedge clk_sys) begin
    #1;
    if (pix_we) begin
      px_a_q.push_back(pix_addr);
      px_d_q.push_back(pix_data);
    end
    if (mem_req && p_req && !mem_ack &&
        (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
      stab_err++;
    p_req  = mem_req;
    p_addr = mem_addr;
    p_we   = mem_we;
    p_wd   = mem_wdata;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (late_ack) begin
      mem_ack  = 1'b1;
      late_ack = 1'b0;
    end else if (ack_en && mem_req && !reset) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        rd_q.push_back(mem_addr);
        mem_rdata = {8'h5A, mem_addr};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d, input int gap);
    dl_wr   = 1'b1;
    dl_addr = 25'(a);
    dl_data = d;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    cyc(gap);
  endtask

  function automatic logic [7:0] hdr_byte(input int i, input int ds,
                                          input int w);
    case (i)
      10: return ds[7:0];
      11: return ds[15:8];
      12: return ds[23:16];
      18: return w[7:0];
      19: return w[15:8];
      default: return 8'(i + 3);
    endcase
  endfunction

  task automatic send_header(input int ds, input int w);
    for (int i = 0; i < 54; i++)
      dl_byte(i, hdr_byte(i, ds, w), 2);
  endtask

  task automatic pulse_line(input logic [8:0] lm, input logic [8:0] ln);
    line_max = lm;
    line_num = ln;
    line_req = 1'b1;
    cyc(1);
    line_req = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int n;
    n = 0;
    cyc(3);
    while (busy && n < 5000) begin
      cyc(1);
      n++;
    end
    ok = !busy;
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_q.delete();
    px_a_q.delete();
    px_d_q.delete();
  endtask

  typedef struct {
    logic [8:0]  lmax;
    logic [8:0]  lnum;
    logic [23:0] first;
  } line_vec_t;

  line_vec_t tv[4];

  initial begin
    logic ok;
    int bad;
    int m;
    int n;

    tv[0] = '{lmax: 9'd312, lnum: 9'd0,   first: 24'd796160};
    tv[1] = '{lmax: 9'd262, lnum: 9'd0,   first: 24'd668160};
    tv[2] = '{lmax: 9'd312, lnum: 9'd400, first: 24'd0};
    tv[3] = '{lmax: 9'd262, lnum: 9'd100, first: 24'd412160};

    // reset values
    cyc(3);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_pix_we", 32'(pix_we), 0);
    chk("rst_pix_addr", 32'(pix_addr), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_loaded", 32'(bmp_loaded), 0);
    chk("rst_err", 32'(bmp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    cyc(2);

    // good download: 54-byte header then 4 payload bytes
    ack_en = 1'b1;
    dl_active = 1'b1;
    cyc(2);
    send_header(54, 640);
    for (int i = 0; i < 4; i++)
      dl_byte(54 + i, 8'(8'hC0 + i), 3);
    cyc(3);
    chk("dl_err_clear", 32'(bmp_err), 0);
    chk("dl_loaded_during", 32'(bmp_loaded), 0);
    dl_active = 1'b0;
    cyc(4);
    chk("dl_loaded", 32'(bmp_loaded), 1);
    chk("dl_wr_count", 32'(wr_addr_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("dl_wr_addr", (i < wr_addr_q.size()) ? 32'(wr_addr_q[i])
                                               : 32'hFFFF_FFFF, 32'(i));
      chk("dl_wr_data", (i < wr_data_q.size()) ? 32'(wr_data_q[i])
                                               : 32'hFFFF_FFFF,
          32'(8'hC0 + i));
    end

    // line fetch table
    for (int t = 0; t < 4; t++) begin
      clear_q();
      pulse_line(tv[t].lmax, tv[t].lnum);
      wait_idle(ok);
      chk("line_done", 32'(ok), 1);
      chk("line_first_addr", (rd_q.size() > 0) ? 32'(rd_q[0])
                                                : 32'hFFFF_FFFF,
          32'(tv[t].first));
      chk("line_reads", 32'(rd_q.size()), 640);
      chk("line_pix", 32'(px_a_q.size()), 640);
      bad = 0;
      foreach (px_a_q[i])
        if (px_a_q[i] != 10'(i) ||
            px_d_q[i] != tv[t].first + 24'(4 * i))
          bad++;
      chk("line_pix_bad", 32'(bad), 0);
      chk("line_busy", 32'(busy), 0);
    end

    // abort: new line request part way through a fetch
    clear_q();
    pulse_line(9'd312, 9'd20);
    n = 0;
    while (px_a_q.size() < 100 && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("abort_reach_100", 32'(px_a_q.size() >= 100), 1);
    pulse_line(9'd312, 9'd5);
    wait_idle(ok);
    chk("abort_done", 32'(ok), 1);
    m = 0;
    while (m < rd_q.size() && rd_q[m] == 24'((291 * 640 + m) * 4))
      m++;
    chk("abort_pos", 32'(m >= 100 && m <= 104), 1);
    chk("abort_reads", 32'(rd_q.size()), 32'(m + 640));
    chk("abort_new_first", (m < rd_q.size()) ? 32'(rd_q[m])
                                              : 32'hFFFF_FFFF, 783360);
    chk("abort_last_pix", (px_a_q.size() > 0)
        ? 32'(px_a_q[px_a_q.size() - 1]) : 32'hFFFF_FFFF, 639);

    // bad width, and line requests ignored while loading / not loaded
    clear_q();
    dl_active = 1'b1;
    cyc(2);
    chk("bw_loaded_clr", 32'(bmp_loaded), 0);
    pulse_line(9'd312, 9'd0);
    cyc(3);
    chk("ign_active_reads", 32'(rd_q.size()), 0);
    send_header(54, 320);
    chk("bw_err", 32'(bmp_err), 1);
    dl_active = 1'b0;
    cyc(4);
    chk("bw_loaded", 32'(bmp_loaded), 0);
    chk("bw_err_hold", 32'(bmp_err), 1);
    pulse_line(9'd312, 9'd0);
    cyc(4);
    chk("ign_unloaded_reads", 32'(rd_q.size()), 0);
    chk("ign_unloaded_busy", 32'(busy), 0);

    // overflow: three back-to-back bytes, memory not answering
    clear_q();
    ack_en = 1'b0;
    dl_active = 1'b1;
    cyc(2);
    chk("ovf_err_clr", 32'(bmp_err), 0);
    dl_byte(10, 8'd20, 1);
    dl_byte(20, 8'h11, 0);
    dl_byte(21, 8'h22, 0);
    chk("ovf_err_two", 32'(bmp_err), 0);
    dl_byte(22, 8'h33, 0);
    chk("ovf_err", 32'(bmp_err), 1);
    cyc(2);
    chk("ovf_mem_req", 32'(mem_req), 1);
    chk("ovf_mem_we", 32'(mem_we), 1);
    chk("ovf_mem_addr", 32'(mem_addr), 0);
    chk("ovf_mem_wdata", 32'(mem_wdata), 32'h11);

    // reset while a request is outstanding, then a stray ack
    dl_active = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("rr_mem_req", 32'(mem_req), 0);
    chk("rr_mem_addr", 32'(mem_addr), 0);
    chk("rr_mem_wdata", 32'(mem_wdata), 0);
    chk("rr_mem_we", 32'(mem_we), 0);
    chk("rr_err", 32'(bmp_err), 0);
    chk("rr_busy", 32'(busy), 0);
    reset = 1'b0;
    late_ack = 1'b1;
    px_a_q.delete();
    cyc(5);
    chk("rr_late_req", 32'(mem_req), 0);
    chk("rr_late_busy", 32'(busy), 0);
    chk("rr_late_pix", 32'(px_a_q.size()), 0);
    chk("rr_late_err", 32'(bmp_err), 0);

    chk("mem_stable", 32'(stab_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
